// File: rtl/rv32_pkg.sv
// ----------------------------------------------------------------------------
// rv32_pkg
// Shared RV32I front-end definitions: machine word width, the bubble
// encoding that matches an IF/ID flush, the sequential PC increment, the
// buffered fetch-entry layout and a PC alignment helper.
// ----------------------------------------------------------------------------
package rv32_pkg;

    localparam int unsigned XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

    localparam word_t BUBBLE_INSTR = 32'h0000_0000;
    localparam word_t PC_STEP      = 32'd4;

    // One buffered instruction together with the address it was fetched from.
    typedef struct packed {
        word_t pc;
        word_t instr;
    } fetch_entry_t;

    // Instruction addresses are always word aligned; the low two bits drop.
    function automatic word_t align_pc(input word_t addr);
        return addr & ~word_t'(3);
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// ----------------------------------------------------------------------------
// if_fetch_unit_if
// Instruction-memory request/response port between the fetch unit and the
// instruction memory.
//   IMEM_REQ     fetch request (master -> slave)
//   IMEM_ADDR    word-aligned fetch address (master -> slave)
//   IMEM_GNT     request accepted this cycle, combinational (slave -> master)
//   IMEM_RVALID  response valid, in request order (slave -> master)
//   IMEM_RDATA   returned instruction word (slave -> master)
// ----------------------------------------------------------------------------
interface if_fetch_unit_if;

    logic                IMEM_REQ;
    rv32_pkg::word_t     IMEM_ADDR;
    logic                IMEM_GNT;
    logic                IMEM_RVALID;
    rv32_pkg::word_t     IMEM_RDATA;

    modport master (
        output IMEM_REQ,
        output IMEM_ADDR,
        input  IMEM_GNT,
        input  IMEM_RVALID,
        input  IMEM_RDATA
    );

    modport slave (
        input  IMEM_REQ,
        input  IMEM_ADDR,
        output IMEM_GNT,
        output IMEM_RVALID,
        output IMEM_RDATA
    );

endinterface

// File: rtl/fetch_fifo.sv
// ----------------------------------------------------------------------------
// fetch_fifo
// Small synchronous FIFO with registered head (no write-through bypass).
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset, empties the FIFO
//   push       write push_data (ignored when full unless popping the same cycle)
//   push_data  entry to write
//   pop        drop the head entry (ignored when empty)
//   flush      synchronous clear; wins over push and pop
//   head_data  oldest entry, valid when empty = 0
//   count      number of stored entries, 0..DEPTH
//   empty      count == 0
// ----------------------------------------------------------------------------
module fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    input  logic                         flush,
    output logic [WIDTH-1:0]             head_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty
);

    localparam int unsigned CW   = $clog2(DEPTH + 1);
    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty & ~flush;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push & ~flush & (~full | do_pop);

    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// ----------------------------------------------------------------------------
// if_fetch_unit
// RV32I instruction-fetch front end. Owns the fetch PC, issues in-order
// requests to instruction memory, buffers returned words and presents them
// to the IF/ID register. A taken branch/jump from EX reloads the PC, flushes
// the buffer and discards responses of requests already in flight.
//   CLK          clock, rising edge
//   nRST         asynchronous active-low reset
//   nEN          downstream stall (1 = hold), same sense as IF/ID
//   REDIRECT     taken branch/jump resolved in EX
//   REDIRECT_PC  redirect target, low two bits ignored
//   imem         instruction-memory port (master side)
//   PC_F         PC of the presented instruction (0 when bubble)
//   PC_Plus4F    PC_F + 4 modulo 2^32 (0 when bubble)
//   Instr_F      presented instruction (0 when bubble)
// ----------------------------------------------------------------------------
module if_fetch_unit
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            nEN,
    input  logic            REDIRECT,
    input  logic [31:0]     REDIRECT_PC,
    if_fetch_unit_if.master imem,
    output logic [31:0]     PC_F,
    output logic [31:0]     PC_Plus4F,
    output logic [31:0]     Instr_F
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned EW = $bits(fetch_entry_t);

    word_t         pc_q;
    logic [CW-1:0] kill_q;

    // The tag queue holds one PC per granted request, so its fill level is
    // the outstanding-request count.
    logic [CW-1:0] out_cnt;
    logic [CW-1:0] occ_cnt;
    logic          tag_empty;
    logic          buf_empty;
    word_t         tag_pc;
    fetch_entry_t  buf_in;
    fetch_entry_t  buf_head;

    logic          issue;
    logic          grant;
    logic          resp;
    logic          discard;
    logic          buf_push;
    logic          buf_pop;
    logic [CW:0]   committed;

    // Slots already claimed once this cycle's pop has freed its entry. A
    // response in the same cycle only moves a claim from out_cnt to occ_cnt.
    assign committed = {1'b0, out_cnt} + {1'b0, occ_cnt} - {{CW{1'b0}}, buf_pop};

    assign issue = nRST & ~REDIRECT & (committed < (CW+1)'(DEPTH));
    assign grant = issue & imem.IMEM_GNT;

    assign imem.IMEM_REQ  = issue;
    assign imem.IMEM_ADDR = pc_q;

    assign resp     = imem.IMEM_RVALID & ~tag_empty;
    assign discard  = (kill_q != '0) | REDIRECT;
    assign buf_push = resp & ~discard;
    assign buf_pop  = ~nEN & ~buf_empty;

    always_comb begin
        buf_in       = '0;
        buf_in.pc    = tag_pc;
        buf_in.instr = imem.IMEM_RDATA;
    end

    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk       (CLK),
        .rst_n     (nRST),
        .push      (grant),
        .push_data (pc_q),
        .pop       (resp),
        .flush     (1'b0),
        .head_data (tag_pc),
        .count     (out_cnt),
        .empty     (tag_empty)
    );

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_buf_fifo (
        .clk       (CLK),
        .rst_n     (nRST),
        .push      (buf_push),
        .push_data (buf_in),
        .pop       (buf_pop),
        .flush     (REDIRECT),
        .head_data (buf_head),
        .count     (occ_cnt),
        .empty     (buf_empty)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pc_q   <= RESET_PC;
            kill_q <= '0;
        end else if (REDIRECT) begin
            pc_q   <= align_pc(REDIRECT_PC);
            // Nothing is granted in a redirect cycle, so whatever remains in
            // flight after this cycle's response is wrong-path.
            kill_q <= out_cnt - CW'(resp);
        end else begin
            if (grant) begin
                pc_q <= pc_q + PC_STEP;
            end
            if (resp && (kill_q != '0)) begin
                kill_q <= kill_q - CW'(1);
            end
        end
    end

    always_comb begin
        PC_F      = '0;
        PC_Plus4F = '0;
        Instr_F   = BUBBLE_INSTR;
        if (!buf_empty) begin
            PC_F      = buf_head.pc;
            PC_Plus4F = buf_head.pc + PC_STEP;
            Instr_F   = buf_head.instr;
        end
    end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch front end of the RV32I pipeline. It owns the program counter, issues in-order requests to the instruction-memory port, buffers returned words, and drives the PC_F / PC_Plus4F / Instr_F inputs of the IF/ID pipeline register. It obeys the same stall (nEN) sense as IF/ID, and accepts taken-branch/jump redirects from EX, discarding wrong-path fetches.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- DEPTH, 2: response buffer entries; also the maximum number of requests outstanding plus buffered.

- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- nEN  in  1  stall from the hazard unit; 1 = downstream holds, same sense as IF/ID nEN.
- REDIRECT  in  1  taken branch/jump resolved in EX.
- REDIRECT_PC  in  32  redirect target; bits [1:0] ignored and forced to 00.
- IMEM_REQ  out  1  fetch request.
- IMEM_ADDR  out  32  word-aligned fetch address.
- IMEM_GNT  in  1  request accepted this cycle (combinational from the port).
- IMEM_RVALID  in  1  response valid; responses arrive in request order, latency ≥1 cycle.
- IMEM_RDATA  in  32  instruction word.
- PC_F  out  32  PC of the presented instruction.
- PC_Plus4F  out  32  PC_F + 4, modulo 2^32.
- Instr_F  out  32  presented instruction.

## Operation
- State: fetch PC (pc_q), outstanding counter (0..DEPTH), kill counter (0..DEPTH), and a DEPTH-entry FIFO of {pc, instr}.
- Issue condition: IMEM_REQ = ~REDIRECT & (outstanding + occupancy − pop < DEPTH). IMEM_ADDR = pc_q.
- On IMEM_REQ & IMEM_GNT: pc_q ← pc_q + 4, wrapping 0xFFFF_FFFC → 0. The PC of each granted request is tagged into a small in-order PC queue; the instruction word is paired with that PC when it returns.
- Response handling: if kill > 0 or REDIRECT is set, the response is dropped and kill is decremented, saturating at 0. Otherwise {pc, IMEM_RDATA} is pushed into the FIFO.
- Output: when the FIFO is non-empty, the head drives PC_F, PC_Plus4F and Instr_F. When the FIFO is empty, all three are 0 (bubble), which is identical to the IF/ID flush encoding.
- Pop: a pop occurs when nEN = 0 and the FIFO is non-empty. When nEN = 1, the outputs hold their values.
- Redirect, which has priority over all other events:
  - pc_q ← {REDIRECT_PC[31:2], 2'b00}.
  - The FIFO is flushed.
  - kill ← the number of requests still in flight after this cycle.
  - No request is issued in the redirect cycle.
  - A pending request that was never granted is withdrawn; the memory port tolerates this.
- Back-to-back redirects: each one reloads pc_q, and kill is recomputed from the current outstanding count.
- Reset (asynchronous, at any time, including mid-burst): pc_q = RESET_PC, counters = 0, FIFO empty, IMEM_REQ = 0, all F outputs = 0. Responses to pre-reset requests are not expected.

## Timing
- First IMEM_REQ goes out in the first cycle after nRST deasserts, with IMEM_ADDR = RESET_PC.
- Latency from response to outputs: a response captured at edge N appears on the outputs after edge N (registered FIFO, no bypass).
- Throughput: with 1-cycle memory latency, GNT always high, and nEN = 0, the unit delivers one instruction per cycle after a 2-cycle fill.
- Full buffer: when outstanding + occupancy = DEPTH and there is no pop, IMEM_REQ is 0.
- Same-cycle response and pop on a full FIFO is legal and leaves occupancy unchanged.
- Redirect at edge N: the first request to the target is issued in cycle N+1. The target instruction reaches the outputs no earlier than edge N+2 plus memory latency. The outputs are 0 during the gap.

## Structure
- Shared package rv32_pkg holds:
  - XLEN = 32.
  - BUBBLE_INSTR = 32'h0000_0000.
  - PC_STEP = 4.
- One sub-module, fetch_fifo: a parameterised synchronous FIFO with push, pop, flush and count, and asynchronous active-low reset. The unit instantiates it twice: once for the {pc, instr} buffer and once as the in-flight PC tag queue.

## Test plan
- Reset release with RESET_PC = 0x100, 1-cycle memory, nEN = 0 → IMEM_ADDR sequence 0x100, 0x104, 0x108, …; from the third cycle, PC_F advances by 4 every cycle and Instr_F matches memory.
- nEN held at 1 for 5 cycles mid-stream → outputs frozen; IMEM_REQ drops within 2 cycles; after release, no instruction is lost or duplicated.
- REDIRECT to 0x2002 with 2 requests in flight → both late responses are dropped; next IMEM_ADDR = 0x2000; next non-bubble PC_F = 0x2000; PC_Plus4F = 0x2004.
- IMEM_GNT held low for 3 cycles → IMEM_ADDR stable; pc_q does not advance; outputs are bubbles (all zero) once the FIFO drains.
- pc_q = 0xFFFF_FFF8 → fetches 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0; PC_Plus4F for 0xFFFF_FFFC is 0x0.
- nRST asserted mid-burst with a full FIFO → all outputs 0 immediately (asynchronously); restart fetches from RESET_PC.
